// File: rtl/count_terminal.sv
// Terminal counter with wrap/one-shot modes, a registered terminal-count pulse,
// a sticky one-shot done flag and a saturating count of terminal events.
module count_terminal #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned WRAP_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_value_i,
  input  logic [WIDTH-1:0]      terminal_i,
  input  logic                  one_shot_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  tc_o,
  output logic                  done_o,
  output logic [WRAP_WIDTH-1:0] wraps_o
);

  localparam logic [WRAP_WIDTH-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [WRAP_WIDTH-1:0] wraps_q, wraps_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  term_hit;

  assign term_hit = enable_i && !done_q && (count_q == terminal_i);

  // Next-state: clear > load > enabled advance/terminal event > hold.
  always_comb begin
    count_d = count_q;
    wraps_d = wraps_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clear_i) begin
      count_d = '0;
      wraps_d = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_value_i;
      done_d  = 1'b0;
    end else if (term_hit) begin
      tc_d = 1'b1;
      if (wraps_q != WRAP_MAX) begin
        wraps_d = wraps_q + WRAP_WIDTH'(1);
      end
      if (one_shot_i) begin
        done_d = 1'b1;
      end else begin
        count_d = '0;
      end
    end else if (enable_i && !done_q) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wraps_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wraps_q <= wraps_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign wraps_o = wraps_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_count_terminal.sv
// Scoreboard bench for count_terminal: a behavioural model queues the expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_count_terminal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, enable, load, one_shot;
  logic [1:0] load_value, terminal;
  logic [1:0] count, count_w2;
  logic       tc, done, tc_w2, done_w2;
  logic [7:0] wraps;
  logic [1:0] wraps_w2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int c;
    int t;
    int d;
    int w;
    int w2;
  } exp_t;

  exp_t sb_q[$];

  int m_c, m_t, m_d, m_w, m_w2;

  always #5 clk = ~clk;

  count_terminal #(.WIDTH(2), .WRAP_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .load_i(load), .load_value_i(load_value), .terminal_i(terminal),
    .one_shot_i(one_shot), .count_o(count), .tc_o(tc), .done_o(done),
    .wraps_o(wraps)
  );

  count_terminal #(.WIDTH(2), .WRAP_WIDTH(2)) dut_w2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .load_i(load), .load_value_i(load_value), .terminal_i(terminal),
    .one_shot_i(one_shot), .count_o(count_w2), .tc_o(tc_w2), .done_o(done_w2),
    .wraps_o(wraps_w2)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_t = 0; m_d = 0; m_w = 0; m_w2 = 0;
  endtask

  // One cycle: drive inputs, predict and queue, clock, pop and compare.
  task automatic step(input bit clr, input bit ld, input int lv, input bit en,
                      input int term, input bit os);
    exp_t e, o;
    clear = clr; load = ld; load_value = 2'(lv); enable = en;
    terminal = 2'(term); one_shot = os;
    m_t = 0;
    if (clr) begin
      m_c = 0; m_w = 0; m_w2 = 0; m_d = 0;
    end else if (ld) begin
      m_c = lv; m_d = 0;
    end else if (en && m_d == 0) begin
      if (m_c == term) begin
        m_t = 1;
        m_w  = (m_w  < 255) ? m_w + 1  : 255;
        m_w2 = (m_w2 < 3)   ? m_w2 + 1 : 3;
        if (os) m_d = 1;
        else    m_c = 0;
      end else begin
        m_c = (m_c + 1) % 4;
      end
    end
    e.c = m_c; e.t = m_t; e.d = m_d; e.w = m_w; e.w2 = m_w2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("count", int'(count), o.c);
    check("tc",    int'(tc),    o.t);
    check("done",  int'(done),  o.d);
    check("wraps", int'(wraps), o.w);
    check("wraps_w2", int'(wraps_w2), o.w2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_tc"},    int'(tc),    0);
    check({tag, "_done"},  int'(done),  0);
    check({tag, "_wraps"}, int'(wraps), 0);
  endtask

  initial begin
    int seq[8];
    int wseq[6];
    rst_n = 1'b0; clear = 0; load = 0; enable = 0; one_shot = 0;
    load_value = 0; terminal = 0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Wrap mode, terminal 3, eight enabled cycles.
    seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 3, 0);
      check("wrap_seq", int'(count), seq[i]);
      check("wrap_tc", int'(tc), (i == 3 || i == 7) ? 1 : 0);
    end
    check("wrap_wraps", int'(wraps), 2);

    // One-shot, terminal 2, then load 0 exits done.
    step(1, 0, 0, 0, 2, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 2, 1);
    check("os_hold", int'(count), 2);
    check("os_done", int'(done), 1);
    step(0, 0, 0, 1, 2, 0);
    check("os_mode_keeps_done", int'(done), 1);
    step(0, 1, 0, 1, 2, 1);
    check("os_load_count", int'(count), 0);
    check("os_load_done", int'(done), 0);

    // Priority: clear beats load and enable; then load beats enable.
    step(0, 0, 0, 1, 3, 0);
    step(1, 1, 3, 1, 3, 0);
    check("prio_clear", int'(count), 0);
    step(0, 1, 3, 1, 3, 0);
    check("prio_load", int'(count), 3);

    // terminal 0 wrap mode: every cycle is an event, small wraps saturates.
    step(1, 0, 0, 0, 0, 0);
    wseq = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 0, 0);
      check("t0_tc", int'(tc), 1);
      check("t0_wraps_w2", int'(wraps_w2), wseq[i]);
    end
    for (int i = 0; i < 260; i++) step(0, 0, 0, 1, 0, 0);
    check("sat_wraps", int'(wraps), 255);

    // count above terminal rolls through max without tc.
    step(0, 1, 3, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    check("above_term_c", int'(count), 0);
    check("above_term_tc", int'(tc), 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    check("above_term_evt", int'(tc), 1);

    // Asynchronous reset mid-count, between edges.
    step(1, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 3, 0);
    check("post_rst", int'(count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_terminal.md
COUNT_TERMINAL -- requirements
Module: count_terminal

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the counter width in bits (legal range 1..16).
REQ-002 Parameter WRAP_WIDTH, default 8, SHALL set the wrap-counter width in bits (legal range 1..16).
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 clear  input  1  SHALL be a synchronous clear of count, wraps, tc and done.
REQ-006 enable  input  1  SHALL request a count advance of one.
REQ-007 load  input  1  SHALL request a synchronous load of load_value into count.
REQ-008 load_value  input  WIDTH  SHALL be the value written to count on load.
REQ-009 terminal  input  WIDTH  SHALL be the terminal count, compared live every cycle.
REQ-010 one_shot  input  1  SHALL select the mode: 0 = wrap (free-running), 1 = one-shot (stop at terminal).
REQ-011 count  output  WIDTH  SHALL be the registered current count.
REQ-012 tc  output  1  SHALL be a registered one-cycle pulse marking a terminal event.
REQ-013 done  output  1  SHALL be a registered sticky flag: one-shot terminal reached.
REQ-014 wraps  output  WRAP_WIDTH  SHALL be a registered, saturating count of terminal events.

Function
REQ-015 Priority SHALL be, per edge: clear > load > enable advance > hold.
REQ-016 clear=1 SHALL set count=0, wraps=0, tc=0, done=0 regardless of other inputs.
REQ-017 load=1 with clear=0 SHALL set count=load_value, tc=0, done=0, and leave wraps unchanged; enable SHALL be ignored that cycle.
REQ-018 enable=0 with no clear/load SHALL hold count, wraps and done, and SHALL drive tc=0 on the next edge.
REQ-019 enable=1, done=0, count!=terminal SHALL set count=(count+1) mod 2^WIDTH and tc=0.
REQ-020 A terminal event SHALL be enable=1, done=0, count==terminal, with no clear/load.
REQ-021 Terminal event, one_shot=0: count SHALL become 0, tc SHALL be 1, and wraps SHALL increment.
REQ-022 Terminal event, one_shot=1: count SHALL hold at terminal, tc SHALL be 1, done SHALL become 1, and wraps SHALL increment.
REQ-023 While done=1, enable SHALL be ignored: count and wraps hold and tc=0; only clear, load or reset exit the state.
REQ-024 tc SHALL never be high on two consecutive cycles unless two consecutive terminal events occur (wrap mode, terminal=0, enable held).
REQ-025 terminal=0 in wrap mode SHALL make every enabled cycle a terminal event; count stays 0.
REQ-026 count>terminal (after load or a terminal change) SHALL advance through 2^WIDTH-1 to 0 with no tc, then reach terminal normally.
REQ-027 wraps SHALL saturate at 2^WRAP_WIDTH-1 and never roll over.
REQ-028 Changing one_shot mid-count SHALL take effect at the next terminal event only; done SHALL NOT be cleared by a mode change.
REQ-029 Latency SHALL be: count, tc, done and wraps reflect an input one edge after it is sampled; there SHALL be no combinational input-to-output path.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for a clock edge, force count=0, tc=0, done=0, wraps=0.
REQ-031 Reset asserted mid-operation SHALL discard any in-progress count, pulse or done state; after release, the first edge SHALL behave as from the reset state.
REQ-032 All outputs SHALL be driven from registers only, with defined values from reset.

Verification
REQ-033 WIDTH=2, terminal=3, one_shot=0, enable held for 8 cycles -> count 1,2,3,0,1,2,3,0; tc high on the edges where count goes 3->0; wraps=2.
REQ-034 terminal=2, one_shot=1, enable held -> count 1,2 then holds at 2; tc high one cycle; done=1 and stays 1 with enable held; then load=1 with load_value=0 -> count=0, done=0.
REQ-035 count=1, clear=1, load=1, enable=1 on the same edge -> count=0, wraps=0, tc=0 (clear wins); next edge load=1, load_value=3, enable=1 -> count=3, no advance.
REQ-036 WRAP_WIDTH=2, terminal=0, wrap mode, enable held 6 cycles -> tc high every cycle, wraps 1,2,3,3,3,3.
REQ-037 Mid-count, reset pulsed low between clock edges -> all outputs 0 asynchronously; after release with enable=1, count=1 on the first edge.
REQ-038 WIDTH=2, load_value=3, terminal=1, enable held -> count 0 (no tc), 1, then terminal event: tc=1 and count=0.
